// File: rtl/lane_rr_arbiter_if.sv
// lane_rr_arbiter_if
//   Bundles the request/grant signals that run between the per-lane
//   requesters and the shared-datapath arbiter.
//   master : requester side  (drives req, last, ds_ready; observes grant status)
//   slave  : arbiter side    (observes req, last, ds_ready; drives grant status)
//   Signals:
//     req[NUM_LANES]   per-lane request, doubles as beat-valid of the granted lane
//     last[NUM_LANES]  per-lane last-beat flag
//     ds_ready         downstream accepts a beat
//     gnt[NUM_LANES]   one-hot grant
//     gnt_id[ID_W]     granted lane index, valid while busy
//     busy             a grant is active
//     beat             beat transferred this cycle
//     beat_cnt[CNT_W]  beats transferred in the current grant
//     forced_rel       one-cycle pulse after a release at MAX_BURST beats
interface lane_rr_arbiter_if #(
  parameter int NUM_LANES = 4,
  parameter int MAX_BURST = 8,
  parameter int ID_W      = $clog2(NUM_LANES),
  parameter int CNT_W     = $clog2(MAX_BURST + 1)
);
  logic [NUM_LANES-1:0] req;
  logic [NUM_LANES-1:0] last;
  logic                 ds_ready;
  logic [NUM_LANES-1:0] gnt;
  logic [ID_W-1:0]      gnt_id;
  logic                 busy;
  logic                 beat;
  logic [CNT_W-1:0]     beat_cnt;
  logic                 forced_rel;

  modport master (
    output req, last, ds_ready,
    input  gnt, gnt_id, busy, beat, beat_cnt, forced_rel
  );

  modport slave (
    input  req, last, ds_ready,
    output gnt, gnt_id, busy, beat, beat_cnt, forced_rel
  );
endinterface

// File: rtl/lane_rr_arbiter.sv
// lane_rr_arbiter
//   Round-robin arbiter sharing one downstream datapath among NUM_LANES
//   requesters. A grant is held for a whole burst and released on the
//   granted lane's last beat, after MAX_BURST beats (forced), or when the
//   granted lane drops its request (abort). Every grant is followed by one
//   idle cycle before the next grant is issued.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    lane_rr_arbiter_if.slave (req/last/ds_ready in; gnt, gnt_id,
//            busy, beat, beat_cnt, forced_rel out)
//   All outputs are registered except beat, which is busy & req[gnt_id] & ds_ready.
module lane_rr_arbiter #(
  parameter int NUM_LANES = 4,
  parameter int MAX_BURST = 8,
  parameter int ID_W      = $clog2(NUM_LANES),
  parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lane_rr_arbiter_if.slave     bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [NUM_LANES-1:0] LANE0_ONEHOT = NUM_LANES'(1);
  localparam logic [ID_W-1:0]      LAST_LANE    = ID_W'(NUM_LANES - 1);
  localparam logic [CNT_W-1:0]     CNT_FINAL    = CNT_W'(MAX_BURST - 1);

  state_t               state_r, state_s;
  logic [ID_W-1:0]      ptr_r, ptr_s;
  logic [NUM_LANES-1:0] gnt_r, gnt_s;
  logic [ID_W-1:0]      gnt_id_r, gnt_id_s;
  logic                 busy_r, busy_s;
  logic [CNT_W-1:0]     beat_cnt_r, beat_cnt_s;
  logic                 forced_rel_r, forced_rel_s;

  logic                 sel_found_s;
  logic [ID_W-1:0]      sel_id_s;
  logic                 beat_s;
  logic                 rel_last_s;
  logic                 rel_force_s;
  logic                 rel_abort_s;
  logic                 release_s;
  logic [ID_W-1:0]      ptr_after_s;

  // Pick the first requesting lane scanning from ptr upward, wrapping to lane 0.
  always_comb begin
    int unsigned idx_v;
    sel_found_s = 1'b0;
    sel_id_s    = ID_W'(0);
    idx_v       = 0;
    for (int i = 0; i < NUM_LANES; i++) begin
      idx_v = int'(ptr_r) + i;
      if (idx_v >= NUM_LANES) begin
        idx_v = idx_v - NUM_LANES;
      end else begin
        idx_v = idx_v;
      end
      if (!sel_found_s && bus.req[ID_W'(idx_v)]) begin
        sel_found_s = 1'b1;
        sel_id_s    = ID_W'(idx_v);
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // Beat and release qualifiers for the currently granted lane.
  always_comb begin
    beat_s      = busy_r & bus.req[gnt_id_r] & bus.ds_ready;
    rel_last_s  = beat_s & bus.last[gnt_id_r];
    rel_force_s = beat_s & (beat_cnt_r == CNT_FINAL);
    rel_abort_s = busy_r & ~bus.req[gnt_id_r];
    release_s   = rel_last_s | rel_force_s | rel_abort_s;
    if (gnt_id_r == LAST_LANE) begin
      ptr_after_s = ID_W'(0);
    end else begin
      ptr_after_s = gnt_id_r + ID_W'(1);
    end
  end

  // Next-state and next-output logic for the IDLE/BUSY grant FSM.
  always_comb begin
    state_s      = state_r;
    ptr_s        = ptr_r;
    gnt_s        = gnt_r;
    gnt_id_s     = gnt_id_r;
    busy_s       = busy_r;
    beat_cnt_s   = beat_cnt_r;
    forced_rel_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (sel_found_s) begin
          state_s    = ST_BUSY;
          gnt_s      = LANE0_ONEHOT << sel_id_s;
          gnt_id_s   = sel_id_s;
          busy_s     = 1'b1;
          beat_cnt_s = CNT_W'(0);
        end else begin
          gnt_s      = NUM_LANES'(0);
          gnt_id_s   = ID_W'(0);
          busy_s     = 1'b0;
          beat_cnt_s = CNT_W'(0);
        end
      end
      ST_BUSY: begin
        if (release_s) begin
          // Release always passes through IDLE, which creates the bubble cycle.
          state_s      = ST_IDLE;
          ptr_s        = ptr_after_s;
          gnt_s        = NUM_LANES'(0);
          gnt_id_s     = ID_W'(0);
          busy_s       = 1'b0;
          beat_cnt_s   = CNT_W'(0);
          forced_rel_s = rel_force_s & ~rel_last_s;
        end else if (beat_s) begin
          beat_cnt_s = beat_cnt_r + CNT_W'(1);
        end else begin
          beat_cnt_s = beat_cnt_r;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        ptr_s      = ID_W'(0);
        gnt_s      = NUM_LANES'(0);
        gnt_id_s   = ID_W'(0);
        busy_s     = 1'b0;
        beat_cnt_s = CNT_W'(0);
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      ptr_r        <= ID_W'(0);
      gnt_r        <= NUM_LANES'(0);
      gnt_id_r     <= ID_W'(0);
      busy_r       <= 1'b0;
      beat_cnt_r   <= CNT_W'(0);
      forced_rel_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      ptr_r        <= ptr_s;
      gnt_r        <= gnt_s;
      gnt_id_r     <= gnt_id_s;
      busy_r       <= busy_s;
      beat_cnt_r   <= beat_cnt_s;
      forced_rel_r <= forced_rel_s;
    end
  end

  assign bus.gnt        = gnt_r;
  assign bus.gnt_id     = gnt_id_r;
  assign bus.busy       = busy_r;
  assign bus.beat       = beat_s;
  assign bus.beat_cnt   = beat_cnt_r;
  assign bus.forced_rel = forced_rel_r;

endmodule

// File: doc/lane_rr_arbiter.md
Name: lane_rr_arbiter

Overview:
- Round-robin arbiter that shares one downstream datapath between NUM_LANES per-lane requesters.
- Requesters are instantiated per lane in a generate loop, indexed by genvar.
- A grant is held for a whole burst, ends on the requester's last beat, and is force-released at MAX_BURST beats.
- Sits between the per-lane generate blocks and the shared output stage.

Parameters:
- NUM_LANES, 4, number of requesters; legal range is 2..16.
- MAX_BURST, 8, maximum beats per grant before forced release; legal range is >= 1.
- ID_W, $clog2(NUM_LANES), width of the lane index.
- CNT_W, $clog2(MAX_BURST+1), width of the beat counter.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NUM_LANES  per-lane request; also serves as the beat-valid of the granted lane.
- last  in  NUM_LANES  per-lane last-beat flag; sampled only for the granted lane.
- ds_ready  in  1  downstream accepts a beat this cycle.
- gnt  out  NUM_LANES  one-hot grant (registered).
- gnt_id  out  ID_W  index of the granted lane; valid while busy=1.
- busy  out  1  a grant is active.
- beat  out  1  beat transferred this cycle; equals busy & req[gnt_id] & ds_ready (combinational).
- beat_cnt  out  CNT_W  beats transferred in the current grant.
- forced_rel  out  1  one-cycle pulse when a grant is released at MAX_BURST.

Behaviour:
- Reset (async assert, sync-to-clk deassert by the system):
  - gnt=0, gnt_id=0, busy=0, beat_cnt=0, forced_rel=0.
  - Priority pointer ptr=0, FSM in IDLE.
  - A reset mid-burst drops the grant immediately; no partial state survives.
- FSM states: IDLE, BUSY.
- IDLE:
  - If req!=0, select the first set bit scanning ptr, ptr+1, ..., wrapping NUM_LANES-1 -> 0.
  - Next cycle: gnt=onehot(sel), gnt_id=sel, busy=1, beat_cnt=0, state -> BUSY.
  - Latency from req to gnt is exactly 1 cycle.
  - If req==0, stay in IDLE; all outputs hold at their reset values.
- BUSY, beat accounting:
  - A beat occurs when req[gnt_id] & ds_ready.
  - Each beat increments beat_cnt (registered).
  - Requests on other lanes are ignored; no preemption.
- BUSY, release conditions (evaluated each cycle):
  - (a) beat & last[gnt_id]: normal release.
  - (b) beat & (beat_cnt == MAX_BURST-1): forced release. forced_rel=1 for the following cycle, only if (a) is not also true.
  - (c) req[gnt_id]==0: abort release. No beat occurs and beat_cnt is not incremented.
- On any release:
  - ptr <= gnt_id+1, wrapping NUM_LANES-1 -> 0.
  - Next cycle: gnt=0, busy=0, beat_cnt=0, state -> IDLE.
- Every grant is followed by exactly one idle (bubble) cycle before the next grant. This is the required, fixed throughput.
- ds_ready low in BUSY: hold the grant and beat_cnt; no timeout.
- last asserted on a non-beat cycle (ds_ready=0) is ignored.
- last on non-granted lanes is ignored.
- beat_cnt never exceeds MAX_BURST-1 while busy. It cannot overflow because CNT_W covers MAX_BURST.
- MAX_BURST=1: every granted beat releases. forced_rel pulses unless last was also set.
- Fairness: a lane that continuously requests is granted within NUM_LANES grants.

Test Plan:
- Reset: assert rst_n=0 mid-burst (lane 2, beat_cnt=3) -> gnt=0, busy=0, beat_cnt=0 in the same cycle; after release, req=4'b0001 gives gnt=4'b0001 one cycle later (ptr=0).
- Round robin: req=4'b1111 held, each lane sends one beat with last=1, ds_ready=1 -> grant order 0,1,2,3,0; one bubble cycle between grants; forced_rel never set.
- Pointer wrap: grant lane 3 and release, then req=4'b1001 -> lane 0 granted, not lane 3.
- Forced release: MAX_BURST=8, lane 1 streams with last=0, ds_ready=1 -> exactly 8 beats, beat_cnt sequence 0..7, forced_rel pulses once, then lane 2 (also requesting) is granted after the bubble.
- Backpressure: lane 0 granted, ds_ready toggling 1,0,0,1 with last=1 on the 4th cycle only -> beat_cnt goes 1,1,1, release after the 4th cycle, last on stall cycles ignored.
- Abort: lane 2 granted, beat_cnt=2, req[2] drops -> busy=0 next cycle, forced_rel=0, ptr=3; req=4'b0101 then grants lane 0 (wrap from ptr=3).
